aging_priority_generator: RTL and testbench

Per-requester aging priority generator for the upstream side of `dynamic_priority_arbiter`. It takes the requests and the arbiter's returned `grant` vector and raises each waiting requester's priority on top of a static base priority. The result is the packed `priorities` bus that drives the arbiter, which bounds starvation whatever fallback arbiter is selected. One instance sits beside each `dynamic_priority_arbiter` and shares its `requests` and `grant` nets.

---
 rtl/aging_priority_generator.sv | 41 ++++
 tb/tb_aging_priority_generator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aging_priority_generator.sv
// aging_priority_generator: raises each waiting requester's priority above its static base,
// saturating at MAX, so the downstream arbiter cannot starve anyone.
module aging_priority_generator #(
  parameter int SIZE = 4,
  parameter int PRIORITY_WIDTH = $clog2(SIZE),
  parameter int PRIORITIES_WIDTH = PRIORITY_WIDTH * SIZE,
  parameter int AGE_STEP = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [SIZE-1:0]             requests,
  input  logic [SIZE-1:0]             grant,
  input  logic [PRIORITIES_WIDTH-1:0] base_priorities,
  output logic [PRIORITIES_WIDTH-1:0] priorities,
  output logic [SIZE-1:0]             starving
);
  localparam int STEP_WIDTH = AGE_STEP > 1 ? $clog2(AGE_STEP) : 1;
  localparam logic [PRIORITY_WIDTH-1:0] MAX = '1;
  localparam logic [STEP_WIDTH-1:0] LAST = STEP_WIDTH'(AGE_STEP - 1);
  if (AGE_STEP < 1) begin : g_bad_age_step
    $error("AGE_STEP must be at least 1");
  end
  for (genvar i = 0; i < SIZE; i++) begin : g_req
    logic [STEP_WIDTH-1:0]     step;
    logic [PRIORITY_WIDTH-1:0] level;
    logic [PRIORITY_WIDTH:0]   sum;
    // a grant clears the age even if the request bit has already dropped
    always_ff @(posedge clock)
      if (!resetn || grant[i] || !requests[i]) begin
        step  <= '0;
        level <= '0;
      end else if (level == MAX) step <= '0;
      else if (step == LAST) begin
        step  <= '0;
        level <= level + 1'b1;
      end else step <= step + 1'b1;
    assign sum = {1'b0, base_priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]} + {1'b0, level};
    assign priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] = sum[PRIORITY_WIDTH] ? MAX : sum[PRIORITY_WIDTH-1:0];
    assign starving[i] = level == MAX;
  end
endmodule

// File: tb/tb_aging_priority_generator.sv
// tb_aging_priority_generator: directed and closed-loop checks of the aging priority generator
// against a per-cycle reference model held in a scoreboard queue.
module tb_aging_priority_generator;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] requests = '0, grant = '0;
  logic [7:0] base_priorities = '0;
  logic [7:0] priorities, p1;
  logic [3:0] starving, s1;
  int vectors = 0, miscompares = 0;
  int ms[4], ml[4];
  typedef struct {logic [7:0] p; logic [3:0] s;} exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  aging_priority_generator dut (
    .clock(clock), .resetn(resetn), .requests(requests), .grant(grant),
    .base_priorities(base_priorities), .priorities(priorities), .starving(starving)
  );
  aging_priority_generator #(.AGE_STEP(1)) u_fast (
    .clock(clock), .resetn(resetn), .requests(requests), .grant(grant),
    .base_priorities(base_priorities), .priorities(p1), .starving(s1)
  );

  // behavioural stand-in for dynamic_priority_arbiter with static-priority tie break
  function automatic logic [3:0] arb(input logic [3:0] r, input logic [7:0] p);
    int b = -1;
    for (int i = 0; i < 4; i++)
      if (r[i] && (b < 0 || p[2*i +: 2] > p[2*b +: 2])) b = i;
    return b < 0 ? 4'b0 : 4'(1 << b);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      int t = int'(base_priorities[2*i +: 2]) + ml[i];
      e.p[2*i +: 2] = 2'(t > 3 ? 3 : t);
      e.s[i] = ml[i] == 3;
    end
    return e;
  endfunction

  task automatic cyc(input logic rn, input logic [3:0] r, input logic [3:0] g);
    exp_t e;
    resetn = rn; requests = r; grant = g;
    for (int i = 0; i < 4; i++)
      if (!rn || g[i] || !r[i]) begin ms[i] = 0; ml[i] = 0; end
      else if (ml[i] == 3) ms[i] = 0;
      else if (ms[i] == 3) begin ms[i] = 0; ml[i]++; end
      else ms[i]++;
    q.push_back(model_out());
    @(posedge clock); #1;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: queue empty, got %h/%b", priorities, starving);
    end else begin
      e = q.pop_front();
      if ({priorities, starving} !== {e.p, e.s}) begin
        miscompares++;
        $display("FAIL scoreboard: got %h/%b want %h/%b", priorities, starving, e.p, e.s);
      end
    end
  endtask

  task automatic test_reset();
    base_priorities = 8'hE4;
    cyc(0, 0, 0); cyc(0, 0, 0);
    vectors++;
    if ({priorities, starving} !== {8'hE4, 4'h0}) begin
      miscompares++; $display("FAIL reset: got %h/%b want e4/0000", priorities, starving);
    end
    repeat (6) cyc(1, 4'hF, 0);
    vectors++;
    if ({priorities, starving} !== {8'hF9, 4'h0}) begin
      miscompares++; $display("FAIL pre_reset_aging: got %h/%b want f9/0000", priorities, starving);
    end
    cyc(0, 4'hF, 0);
    vectors++;
    if ({priorities, starving} !== {8'hE4, 4'h0}) begin
      miscompares++; $display("FAIL mid_aging_reset: got %h/%b want e4/0000", priorities, starving);
    end
  endtask

  task automatic test_aging();
    base_priorities = 8'h00;
    cyc(0, 0, 0);
    for (int e = 1; e <= 20; e++) begin
      logic [1:0] f0, f1;
      cyc(1, 4'b0001, 0);
      f0 = e < 4 ? 2'd0 : e < 8 ? 2'd1 : e < 12 ? 2'd2 : 2'd3;
      f1 = e < 3 ? 2'(e) : 2'd3;
      vectors++;
      if ({priorities, starving} !== {6'b0, f0, 3'b0, e >= 12}) begin
        miscompares++; $display("FAIL aging edge %0d: got %h/%b want %h/%b", e, priorities, starving, f0, e >= 12);
      end
      vectors++;
      if ({p1, s1} !== {6'b0, f1, 3'b0, e >= 3}) begin
        miscompares++; $display("FAIL aging_step1 edge %0d: got %h/%b want %h", e, p1, s1, f1);
      end
    end
  endtask

  task automatic test_grant_clear();
    cyc(1, 4'b0001, 4'b0001);
    vectors++;
    if ({priorities, starving} !== {8'h00, 4'h0}) begin
      miscompares++; $display("FAIL grant_clear: got %h/%b want 00/0000", priorities, starving);
    end
    for (int e = 1; e <= 4; e++) begin
      cyc(1, 4'b0001, 0);
      vectors++;
      if (priorities !== (e == 4 ? 8'h01 : 8'h00)) begin
        miscompares++; $display("FAIL regrow edge %0d: got %h", e, priorities);
      end
    end
  endtask

  task automatic test_saturate();
    base_priorities = 8'h08;
    cyc(0, 0, 0);
    for (int e = 1; e <= 12; e++) begin
      cyc(1, 4'b0010, 0);
      vectors++;
      if ({priorities, starving} !== {(e < 4 ? 8'h08 : 8'h0C), (e >= 12 ? 4'b0010 : 4'b0)}) begin
        miscompares++; $display("FAIL saturate edge %0d: got %h/%b", e, priorities, starving);
      end
    end
  endtask

  task automatic test_withdraw();
    base_priorities = 8'h10;
    cyc(0, 0, 0);
    repeat (6) cyc(1, 4'b0100, 0);
    vectors++;
    if (priorities !== 8'h20) begin
      miscompares++; $display("FAIL withdraw_pre: got %h want 20", priorities);
    end
    cyc(1, 0, 0);
    vectors++;
    if (priorities !== 8'h10) begin
      miscompares++; $display("FAIL withdraw: got %h want 10", priorities);
    end
    for (int e = 1; e <= 4; e++) begin
      cyc(1, 4'b0100, 0);
      vectors++;
      if (priorities !== (e == 4 ? 8'h20 : 8'h10)) begin
        miscompares++; $display("FAIL reassert edge %0d: got %h", e, priorities);
      end
    end
  endtask

  task automatic test_multi_grant();
    base_priorities = 8'h00;
    cyc(0, 0, 0);
    repeat (5) cyc(1, 4'hF, 0);
    cyc(1, 4'hF, 4'b0101);
    vectors++;
    if ({priorities, starving} !== {8'h44, 4'h0}) begin
      miscompares++; $display("FAIL multi_grant: got %h/%b want 44/0000", priorities, starving);
    end
    cyc(1, 4'h0, 4'hF);
    vectors++;
    if (priorities !== 8'h00) begin
      miscompares++; $display("FAIL grant_no_request: got %h want 00", priorities);
    end
  endtask

  task automatic test_closed_loop();
    int wait_cnt[4] = '{default: 0};
    int starve_cnt[4] = '{default: 0};
    int max_wait = 0, max_starve = 0;
    base_priorities = 8'h00;
    cyc(0, 0, 0);
    repeat (300) begin
      logic [3:0] g;
      g = arb(4'hF, priorities);
      cyc(1, 4'hF, g);
      for (int i = 0; i < 4; i++) begin
        wait_cnt[i] = g[i] ? 0 : wait_cnt[i] + 1;
        starve_cnt[i] = starving[i] ? starve_cnt[i] + 1 : 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        if (starve_cnt[i] > max_starve) max_starve = starve_cnt[i];
      end
    end
    vectors++;
    if (max_wait > 16) begin
      miscompares++; $display("FAIL starvation_bound: longest wait %0d want <= 16", max_wait);
    end
    vectors++;
    if (max_starve > 4) begin
      miscompares++; $display("FAIL starving_duration: longest %0d want <= 4", max_starve);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] r;
      r = 4'($urandom);
      base_priorities = 8'($urandom);
      #1;
      cyc($urandom_range(63) != 0, r, arb(r, priorities));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_aging();
    test_grant_clear();
    test_saturate();
    test_withdraw();
    test_multi_grant();
    test_closed_loop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
